// File: rtl/fpu_pkg.sv
// fpu_pkg: types shared by the FP write-back path.
//   fp32_t     - raw 32-bit single-precision value
//   freg_idx_t - FP register file index (32 registers)
//   wb_entry_t - one buffered result: destination, data, overflow flag
package fpu_pkg;

  typedef logic [31:0] fp32_t;
  typedef logic [4:0]  freg_idx_t;

  typedef struct packed {
    freg_idx_t rd;
    fp32_t     data;
    logic      ovf;
  } wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: first-word-fall-through result buffer.
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_entry this cycle
//   push_entry - entry to store
//   pop        - consume the head this cycle (ignored when empty)
//   head       - current head entry, zero while empty
//   count      - current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is forced to zero while empty so stale storage never shows.
  assign head  = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fsub_wb.sv
// fsub_wb: write-back stage for a fixed-latency fsub unit.
//   clk, rst     - clock, synchronous active-high reset
//   issue_valid  - an fsub operation is offered this cycle
//   issue_rd     - destination register of that operation
//   issue_ready  - a credit is free; the issue is taken when both are high
//   y, ovf       - fsub result and overflow, valid LAT cycles after issue
//   wb_valid     - buffer head holds a result
//   wb_ready     - register file takes the head this cycle
//   wb_rd, wb_data, wb_ovf - head entry
//   ovf_sticky   - sticky overflow status
//   ovf_clear    - clears ovf_sticky
// Macro FSUB_WB_OVF_STICKY_EN builds the sticky overflow register; without
// it ovf_sticky is tied low and ovf_clear is ignored.
module fsub_wb
  import fpu_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  freg_idx_t issue_rd,
  output logic      issue_ready,
  input  fp32_t     y,
  input  logic      ovf,
  output logic      wb_valid,
  input  logic      wb_ready,
  output freg_idx_t wb_rd,
  output fp32_t     wb_data,
  output logic      wb_ovf,
  output logic      ovf_sticky,
  input  logic      ovf_clear
);

  // Wide enough for every tag-pipe stage plus a full buffer.
  localparam int CW = $clog2(LAT + DEPTH + 1);

  logic [LAT-1:0]        valid_pipe_reg;
  freg_idx_t             rd_pipe_reg [LAT];
  logic                  issue_fire;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CW-1:0]         pipe_count;
  logic [CW-1:0]         credit_used;

  assign issue_fire = issue_valid && issue_ready;

  // Tag pipe stage 0 samples the issue port every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_pipe_reg[0] <= 1'b0;
      rd_pipe_reg[0]    <= '0;
    end else begin
      valid_pipe_reg[0] <= issue_fire;
      rd_pipe_reg[0]    <= issue_rd;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_pipe_reg[gi] <= 1'b0;
          rd_pipe_reg[gi]    <= '0;
        end else begin
          valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
          rd_pipe_reg[gi]    <= rd_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // The last stage lines up with the fsub result; y/ovf are captured only then.
  assign push       = valid_pipe_reg[LAT-1];
  assign push_entry = '{rd: rd_pipe_reg[LAT-1], data: y, ovf: ovf};

  fpu_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign wb_valid = (fifo_count != '0);
  assign pop      = wb_valid && wb_ready;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;
  assign wb_ovf   = head.ovf;

  // Every in-flight tag already owns a buffer slot, so a push never finds
  // the buffer full. Only registered state feeds issue_ready.
  always_comb begin
    pipe_count = '0;
    for (int i = 0; i < LAT; i++) begin
      pipe_count = pipe_count + CW'(valid_pipe_reg[i]);
    end
  end

  assign credit_used = pipe_count + CW'(fifo_count);
  assign issue_ready = (credit_used < CW'(DEPTH));

`ifdef FSUB_WB_OVF_STICKY_EN
  logic sticky_reg;

  // Setting has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else if (pop && head.ovf) begin
      sticky_reg <= 1'b1;
    end else if (ovf_clear) begin
      sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky = sticky_reg;
`else
  logic unused_ovf_clear;

  assign unused_ovf_clear = ovf_clear;
  assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_fsub_wb.sv
module tb_fsub_wb;
  import fpu_pkg::*;

`ifdef FSUB_WB_OVF_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: LAT=1, DEPTH=4
  logic        a_rst = 1'b1, a_iv = 1'b0, a_ovf = 1'b0, a_wr = 1'b0, a_clr = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_y = '0;
  logic        a_ready, a_wv, a_wovf, a_sticky;
  logic [4:0]  a_wrd;
  logic [31:0] a_wdata;

  // DUT b: LAT=3, DEPTH=4
  logic        b_rst = 1'b1, b_iv = 1'b0, b_ovf = 1'b0, b_wr = 1'b0, b_clr = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_y = '0;
  logic        b_ready, b_wv, b_wovf, b_sticky;
  logic [4:0]  b_wrd;
  logic [31:0] b_wdata;

  fsub_wb #(.LAT(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(a_rst), .issue_valid(a_iv), .issue_rd(a_rd), .issue_ready(a_ready),
    .y(a_y), .ovf(a_ovf), .wb_valid(a_wv), .wb_ready(a_wr), .wb_rd(a_wrd),
    .wb_data(a_wdata), .wb_ovf(a_wovf), .ovf_sticky(a_sticky), .ovf_clear(a_clr)
  );

  fsub_wb #(.LAT(3), .DEPTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .issue_valid(b_iv), .issue_rd(b_rd), .issue_ready(b_ready),
    .y(b_y), .ovf(b_ovf), .wb_valid(b_wv), .wb_ready(b_wr), .wb_rd(b_wrd),
    .wb_data(b_wdata), .wb_ovf(b_wovf), .ovf_sticky(b_sticky), .ovf_clear(b_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkdat(input logic [4:0] r);
    return 32'h4120_0000 ^ {r, r, r, r, r, r, 2'b01};
  endfunction

  function automatic logic mkovf(input logic [4:0] r);
    return r[0];
  endfunction

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] y;
    logic        ovf;
    logic        wr;
    logic        clr;
    logic        e_ready;
    logic        e_wv;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_ovf;
    logic        e_sticky;  // value expected when the sticky feature is built
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic [31:0] y,
                              input logic ov, input logic wr, input logic clr,
                              input logic e_ready, input logic e_wv, input logic [4:0] e_rd,
                              input logic [31:0] e_data, input logic e_ovf, input logic e_sticky);
    vec_t v;
    v.iv = iv; v.rd = rd; v.y = y; v.ovf = ov; v.wr = wr; v.clr = clr;
    v.e_ready = e_ready; v.e_wv = e_wv; v.e_rd = e_rd; v.e_data = e_data;
    v.e_ovf = e_ovf; v.e_sticky = e_sticky;
    return v;
  endfunction

  // Scoreboard for DUT a sequences: rd values in issue order.
  logic [4:0] sb[$];
  logic       pend_v  = 1'b0;
  logic [4:0] pend_rd = '0;
  logic       acc;
  int         pops;

  // One cycle on DUT a; y/ovf follow the issue accepted one cycle earlier.
  task automatic a_cycle(input logic iv, input logic [4:0] rd, input logic wr);
    logic [4:0] e;
    @(negedge clk);
    a_iv = iv; a_rd = rd; a_wr = wr; a_clr = 1'b0;
    a_y   = pend_v ? mkdat(pend_rd) : 32'hDEAD_BEEF;
    a_ovf = pend_v ? mkovf(pend_rd) : 1'b1;
    #1;
    if (a_wv && wr) begin
      pops++;
      if (sb.size() == 0) begin
        chk("unexpected_pop", 32'(a_wrd), 32'h0000_00FF);
      end else begin
        e = sb.pop_front();
        chk("seq_rd", 32'(a_wrd), 32'(e));
        chk("seq_data", a_wdata, mkdat(e));
        chk("seq_ovf", 32'(a_wovf), 32'(mkovf(e)));
      end
    end
    acc = iv && a_ready;
    if (acc) sb.push_back(rd);
    pend_v  = acc;
    pend_rd = rd;
  endtask

  task automatic b_cycle(input logic iv, input logic [4:0] rd, input logic [31:0] yv,
                         input logic ov, input logic wr, input logic rs);
    @(negedge clk);
    b_iv = iv; b_rd = rd; b_y = yv; b_ovf = ov; b_wr = wr; b_rst = rs; b_clr = 1'b0;
    #1;
  endtask

  vec_t vecs[17];
  int   n_acc;

  initial begin
    // Both DUTs in reset with issue_valid held high: it must be ignored.
    @(negedge clk);
    a_rst = 1'b1; a_iv = 1'b1; a_rd = 5'd31;
    b_rst = 1'b1; b_iv = 1'b1; b_rd = 5'd30;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; a_iv = 1'b0;
    b_rst = 1'b0; b_iv = 1'b0;

    //           iv rd     y             ov wr clr  rdy wv rd     data          ov st
    vecs[0]  = mk(0, 5'd0, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[1]  = mk(1, 5'd3, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[2]  = mk(0, 5'd0, 32'hBF7A2000, 0, 1, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[3]  = mk(0, 5'd0, 32'h0,        0, 1, 0,   1, 1, 5'd3, 32'hBF7A2000, 0, 0);
    vecs[4]  = mk(0, 5'd0, 32'h0,        0, 1, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[5]  = mk(1, 5'd7, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[6]  = mk(0, 5'd0, 32'h7F800000, 1, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[7]  = mk(0, 5'd0, 32'h0,        0, 0, 0,   1, 1, 5'd7, 32'h7F800000, 1, 0);
    vecs[8]  = mk(0, 5'd0, 32'h0,        0, 1, 0,   1, 1, 5'd7, 32'h7F800000, 1, 0);
    vecs[9]  = mk(0, 5'd0, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 1);
    vecs[10] = mk(0, 5'd0, 32'h0,        0, 0, 1,   1, 0, 5'd0, 32'h0,        0, 1);
    vecs[11] = mk(0, 5'd0, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[12] = mk(1, 5'd9, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[13] = mk(0, 5'd0, 32'h3F800000, 1, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);
    vecs[14] = mk(0, 5'd0, 32'h0,        0, 1, 1,   1, 1, 5'd9, 32'h3F800000, 1, 0);
    vecs[15] = mk(0, 5'd0, 32'h0,        0, 0, 1,   1, 0, 5'd0, 32'h0,        0, 1);
    vecs[16] = mk(0, 5'd0, 32'h0,        0, 0, 0,   1, 0, 5'd0, 32'h0,        0, 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_iv = vecs[i].iv; a_rd = vecs[i].rd; a_y = vecs[i].y; a_ovf = vecs[i].ovf;
      a_wr = vecs[i].wr; a_clr = vecs[i].clr;
      #1;
      $display("vec %0d: ready=%0b wv=%0b rd=%0d data=%h ovf=%0b sticky=%0b",
               i, a_ready, a_wv, a_wrd, a_wdata, a_wovf, a_sticky);
      chk($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_wv", i), 32'(a_wv), 32'(vecs[i].e_wv));
      chk($sformatf("vec%0d_sticky", i), 32'(a_sticky), 32'(vecs[i].e_sticky & STICKY_ON));
      if (vecs[i].e_wv || i == 0) begin
        chk($sformatf("vec%0d_rd", i), 32'(a_wrd), 32'(vecs[i].e_rd));
        chk($sformatf("vec%0d_data", i), a_wdata, vecs[i].e_data);
        chk($sformatf("vec%0d_ovf", i), 32'(a_wovf), 32'(vecs[i].e_ovf));
      end
    end
    a_clr = 1'b0;

    // Fill with wb_ready low: exactly DEPTH issues accepted, then drain in order.
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      a_cycle(1'b1, 5'(10 + k), 1'b0);
      if (acc) n_acc++;
    end
    $display("fill: accepted=%0d ready=%0b", n_acc, a_ready);
    chk("fill_accepted", 32'(n_acc), 32'd4);
    chk("fill_ready_low", 32'(a_ready), 32'd0);
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      a_cycle(1'b0, 5'd0, 1'b1);
      $display("drain %0d: wv=%0b rd=%0d", k, a_wv, a_wrd);
    end
    chk("drain_pops", 32'(pops), 32'd4);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Refill, then hold issue and wb_ready high: one result every cycle.
    for (int k = 0; k < 6; k++) a_cycle(1'b1, 5'(k), 1'b0);
    pops = 0;
    for (int k = 0; k < 24; k++) begin
      a_cycle(1'b1, 5'(8 + k), 1'b1);
      $display("steady %0d: wv=%0b rd=%0d ready=%0b", k, a_wv, a_wrd, a_ready);
      if (k >= 4) chk($sformatf("steady%0d_wv", k), 32'(a_wv), 32'd1);
    end
    chk("steady_pops", 32'(pops), 32'd24);
    for (int k = 0; k < 10; k++) a_cycle(1'b0, 5'd0, 1'b1);
    chk("steady_sb_empty", 32'(sb.size()), 32'd0);
    chk("steady_final_wv", 32'(a_wv), 32'd0);

    // LAT=3: issues 1,2,5 back to back appear 4 cycles after the first issue.
    begin
      logic [4:0] iss_rd[9];
      logic       iss_v[9];
      logic [4:0] res_rd[9];
      logic       exp_wv[9];
      logic [4:0] exp_rd[9];
      for (int c = 0; c < 9; c++) begin
        iss_v[c] = 1'b0; iss_rd[c] = '0; res_rd[c] = '0; exp_wv[c] = 1'b0; exp_rd[c] = '0;
      end
      iss_v[0] = 1'b1; iss_rd[0] = 5'd1;
      iss_v[1] = 1'b1; iss_rd[1] = 5'd2;
      iss_v[2] = 1'b1; iss_rd[2] = 5'd5;
      res_rd[3] = 5'd1; res_rd[4] = 5'd2; res_rd[5] = 5'd5;
      exp_wv[4] = 1'b1; exp_rd[4] = 5'd1;
      exp_wv[5] = 1'b1; exp_rd[5] = 5'd2;
      exp_wv[6] = 1'b1; exp_rd[6] = 5'd5;
      for (int c = 0; c < 9; c++) begin
        b_cycle(iss_v[c], iss_rd[c], mkdat(res_rd[c]), mkovf(res_rd[c]), 1'b1, 1'b0);
        $display("lat3 %0d: wv=%0b rd=%0d data=%h", c, b_wv, b_wrd, b_wdata);
        chk($sformatf("lat3_c%0d_wv", c), 32'(b_wv), 32'(exp_wv[c]));
        if (exp_wv[c]) begin
          chk($sformatf("lat3_c%0d_rd", c), 32'(b_wrd), 32'(exp_rd[c]));
          chk($sformatf("lat3_c%0d_data", c), b_wdata, mkdat(exp_rd[c]));
        end
      end
    end

    // Reset with two results buffered and two in the tag pipe.
    b_cycle(1'b1, 5'd20, 32'h0, 1'b0, 1'b0, 1'b0);
    b_cycle(1'b1, 5'd21, 32'h0, 1'b0, 1'b0, 1'b0);
    b_cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    b_cycle(1'b0, 5'd0, mkdat(5'd20), 1'b0, 1'b0, 1'b0);
    b_cycle(1'b0, 5'd0, mkdat(5'd21), 1'b1, 1'b0, 1'b0);
    b_cycle(1'b1, 5'd22, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_ready", 32'(b_ready), 32'd1);
    b_cycle(1'b1, 5'd23, 32'h0, 1'b0, 1'b0, 1'b0);
    b_cycle(1'b1, 5'd24, 32'h0, 1'b0, 1'b0, 1'b1);
    $display("pre-reset: wv=%0b rd=%0d", b_wv, b_wrd);
    chk("rst_pre_wv", 32'(b_wv), 32'd1);
    chk("rst_pre_rd", 32'(b_wrd), 32'd20);
    for (int c = 0; c < 10; c++) begin
      b_cycle(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      $display("post-reset %0d: wv=%0b ready=%0b", c, b_wv, b_ready);
      chk($sformatf("rst_post%0d_wv", c), 32'(b_wv), 32'd0);
      chk($sformatf("rst_post%0d_ready", c), 32'(b_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
